serial_bit_feeder: RTL

//   Parallel-in/serial-out stage that sits directly upstream of the Mealy sequence detectors.

---
 rtl/ser_pkg.sv | 15 +
 rtl/serial_bit_feeder_if.sv | 11 +
 rtl/ser_bit_counter.sv | 28 ++
 rtl/serial_bit_feeder.sv | 99 +++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and frame-length helper for the serial bit feeder.
// Optional feature macro: SER_PARITY_EN (appends an even-parity bit to each frame).
package ser_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  function automatic int unsigned ser_frame_len(input int unsigned width);
`ifdef SER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Word-load handshake between a producer (master) and the serial bit feeder (slave).
interface serial_bit_feeder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/ser_bit_counter.sv
// Bit-position counter for one frame; restarts on start, saturates at FRAME_LEN-1.
module ser_bit_counter #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          start,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic          last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (advance && !last) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == LAST_IDX);

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-in/serial-out feeder: streams accepted words onto x one bit per cycle, gapless.
// Optional feature macro: SER_PARITY_EN (even-parity bit appended after the data bits).
module serial_bit_feeder
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic                clk,
  input  logic                clear_n,
  serial_bit_feeder_if.slave  load,
  output logic                x,
  output logic                x_valid,
  output logic                frame_done
);

  localparam int unsigned FRAME_LEN = ser_frame_len(WIDTH);
  localparam int unsigned CW        = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  ser_state_t           state_q, state_d;
  logic [CW-1:0]        count;
  logic                 last;
  logic                 accept;
  logic [WIDTH-1:0]     ordered;
  logic [FRAME_LEN-1:0] frame;
  logic [FRAME_LEN-1:0] sr;

  assign accept = load.load_valid && load.load_ready;

  ser_bit_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CW        (CW)
  ) u_counter (
    .clk     (clk),
    .clear_n (clear_n),
    .start   (accept),
    .advance (state_q == SHIFT),
    .count   (count),
    .last    (last)
  );

  // Frame is arranged so the next bit to send always sits at the top of the word.
  always_comb begin
    ordered = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ordered[i] = (MSB_FIRST != 0) ? load.load_data[i] : load.load_data[WIDTH-1-i];
    end
  end

`ifdef SER_PARITY_EN
  assign frame = {ordered, ^load.load_data};
`else
  assign frame = ordered;
`endif

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load.load_ready = (state_q == IDLE) || ((state_q == SHIFT) && last);
    frame_done      = (state_q == SHIFT) && (count == LAST_IDX);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
      sr      <= '0;
    end else if (accept) begin
      x       <= frame[FRAME_LEN-1];
      x_valid <= 1'b1;
      sr      <= {frame[FRAME_LEN-2:0], 1'b0};
    end else if ((state_q == SHIFT) && !last) begin
      x       <= sr[FRAME_LEN-1];
      x_valid <= 1'b1;
      sr      <= {sr[FRAME_LEN-2:0], 1'b0};
    end else begin
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
    end
  end

endmodule
